mod_updown_counter: RTL
=======================

# mod_updown_counter

Parametrised modulo-N up/down counter. It generalises the team's 4-bit free-running up counter with programmable width and modulus, direction control, count enable, synchronous load and clear, and wrap or saturate modes. It also provides a registered carry/borrow pulse and a sticky overflow flag. It is the standard counting primitive for dividers, BCD digit chains (MOD=10, cascaded through `tc`) and timeout logic.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 1..32.
- `MOD`, default 16: modulus; count range is 0..MOD-1; legal range 2..2^WIDTH.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clock `clk`.
- `en`  in  1  count enable.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `sat`  in  1  mode: 0 = wrap at limits, 1 = saturate at limits.
- `clr`  in  1  synchronous clear.
- `load`  in  1  synchronous load.
- `load_val`  in  WIDTH  value for `load`.
- `q`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal count, combinational; usable as `en` of the next cascaded stage.
- `co`  out  1  carry/borrow pulse, registered, one cycle wide.
- `ovf`  out  1  sticky limit-hit flag, registered.

## Operation
- Priority per rising edge is `rst` (async) > `clr` > `load` > `en` count > hold.
- **`rst` high:** `q`=0, `co`=0, `ovf`=0 immediately, without waiting for `clk`. `q` is held at 0 for as long as `rst` is high.
- **`clr`:** `q`<=0, `co`<=0, `ovf`<=0.
- **`load`:**
  - `q`<=`load_val` if `load_val` < MOD; otherwise `q`<=MOD-1 (clamped).
  - `co`<=0 and `ovf` is unchanged.
- **`en` with `up`=1:**
  - `q` < MOD-1: `q`<=`q`+1 and `co`<=0.
  - `q` = MOD-1 with `sat`=0: `q`<=0 and `co`<=1.
  - `q` = MOD-1 with `sat`=1: `q` holds at MOD-1, `co`<=0, `ovf`<=1.
- **`en` with `up`=0:**
  - `q` > 0: `q`<=`q`-1 and `co`<=0.
  - `q` = 0 with `sat`=0: `q`<=MOD-1 and `co`<=1.
  - `q` = 0 with `sat`=1: `q` holds at 0, `co`<=0, `ovf`<=1.
- **Hold (none of the above active):** `q` unchanged and `co`<=0.
- **`tc`** = `en` & (`up` ? `q`==MOD-1 : `q`==0). It is independent of `sat`, `clr` and `load`.
- **`ovf`** is only cleared by `rst` or `clr`.
- **Arithmetic:** compute at WIDTH+1 bits internally, so MOD=2^WIDTH wraps correctly with no truncation glitch. `q` never leaves 0..MOD-1.
- **Direction or mode changes** take effect on the same edge they are sampled. No internal state exists beyond `q`, `co` and `ovf`.

## Timing
- **Latency:** one clock from `en`/`load`/`clr` to `q`. `co` asserts in the same cycle that `q` shows the wrapped value.
- **`tc`** is combinational from `q`, `en` and `up`; it is valid in the cycle before the wrap edge.
- **Reset assertion** at any point, including mid-count or while `co`=1, clears all outputs asynchronously.
- **Reset release:** the first rising edge after `rst` deasserts is processed normally. With `en`=1 and `up`=1, `q` goes to 1.
- **`clr` and `load` together:** `clr` wins and `q`=0.
- **`load` and `en` together:** `load` wins and no count occurs on that edge.

## Test plan
- Reset: drive counts, assert `rst` asynchronously between edges -> `q`=0, `co`=0, `ovf`=0 before the next edge. Release with `en`=1, `up`=1 -> `q`=1 after one edge.
- Wrap up (WIDTH=4, MOD=10, `sat`=0, `up`=1): 10 enabled edges from 0 -> `q` goes 1..9,0. `tc`=1 while `q`=9. `co`=1 only in the cycle `q`=0. `ovf` stays 0.
- Wrap down (MOD=10): from 0, one edge with `up`=0 -> `q`=9 and `co`=1. Next edge -> `q`=8 and `co`=0.
- Saturate (MOD=10, `sat`=1): load 8, then 3 edges with `up`=1 -> `q`=9,9,9, `ovf`=1, `co` never set. Then `clr` -> `q`=0 and `ovf`=0.
- Load and priority: `load_val`=12 with MOD=10 -> `q`=9. `load`+`clr` together -> `q`=0. `load`=1, `en`=1, `load_val`=5 -> `q`=5 with no increment.
- Full-range modulus (WIDTH=4, MOD=16): from 15 with `up`=1 -> `q`=0 and `co`=1. Then 1 edge with `up`=0 -> `q`=15 and `co`=1. Two stages with MOD=10 cascaded via `tc`->`en` count 00..99 and wrap to 00.

Source files
------------

// File: rtl/mod_updown_counter.sv
// Parametrised modulo-MOD up/down counter with wrap or saturate behaviour,
// a registered carry/borrow pulse, a sticky limit-hit flag and a
// combinational terminal-count output for cascading stages.
module mod_updown_counter #(
    parameter int unsigned     WIDTH = 4,
    parameter longint unsigned MOD   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             co,
    output logic             ovf
);

    // Limits are held one bit wider than q so MOD = 2^WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_X  = MOD[WIDTH:0];
    localparam logic [WIDTH:0]   ONE_X  = (WIDTH + 1)'(1);
    localparam logic [WIDTH:0]   LAST_X = MOD_X - ONE_X;
    localparam logic [WIDTH-1:0] LAST   = LAST_X[WIDTH-1:0];

    logic [WIDTH:0] inc_x;
    logic [WIDTH:0] dec_x;
    logic           at_max;
    logic           at_zero;

    // Out-of-range load values are clamped to the top of the count range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] v_x;
        v_x = {1'b0, v};
        return (v_x < MOD_X) ? v : LAST;
    endfunction

    // The increment reaching MOD marks the top limit; a borrow out of the
    // extra bit on decrement marks the bottom limit.
    assign inc_x   = {1'b0, q} + ONE_X;
    assign dec_x   = {1'b0, q} - ONE_X;
    assign at_max  = (inc_x == MOD_X);
    assign at_zero = dec_x[WIDTH];

    assign tc = en & (up ? at_max : at_zero);

    // Count state: reset > clear > load > count > hold; co is a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            co  <= 1'b0;
            ovf <= 1'b0;
        end else if (clr) begin
            q   <= '0;
            co  <= 1'b0;
            ovf <= 1'b0;
        end else if (load) begin
            q  <= clamp_load(load_val);
            co <= 1'b0;
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    q  <= inc_x[WIDTH-1:0];
                    co <= 1'b0;
                end else if (sat) begin
                    co  <= 1'b0;
                    ovf <= 1'b1;
                end else begin
                    q  <= '0;
                    co <= 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    q  <= dec_x[WIDTH-1:0];
                    co <= 1'b0;
                end else if (sat) begin
                    co  <= 1'b0;
                    ovf <= 1'b1;
                end else begin
                    q  <= LAST;
                    co <= 1'b1;
                end
            end
        end else begin
            co <= 1'b0;
        end
    end

endmodule
